video_pixel_src: RTL and testbench

//  Head-of-chain pixel source for the video core pipeline. Sits directly upstream of the

---
 rtl/video_pixel_src.sv | 197 +++++++++++++++++++
 tb/tb_video_pixel_src.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/video_pixel_src.sv
// video_pixel_src
//   Head-of-chain pixel source for the video pipeline. Walks an HSIZE x VSIZE
//   frame in raster order under a vld/rdy handshake and fills every beat with
//   a background colour, either solid or a 32x32 checkerboard. Colour and mode
//   are written over a small Avalon write-only register port. They are latched
//   into shadow registers only when the first beat of a frame is loaded, so a
//   frame never shows a mix of two settings.
//
// Ports
//   clk            pipeline clock
//   rst            synchronous active-high reset
//   avs_write      register write strobe
//   avs_address    register byte address (0x0 ctrl, 0x4 bg_color)
//   avs_writedata  register write data
//   snk_rdy        downstream ready
//   snk_vld        beat valid
//   snk_fc         frame counters (hc/vc driven, other fields zero)
//   snk_rgb        pixel colour
//   snk_sof        first beat of a frame
//   snk_eof        last beat of a frame

package video_pkg;
  localparam int FC_CNT_W = 11;

  typedef struct packed {
    logic [FC_CNT_W-1:0] hc;
    logic [FC_CNT_W-1:0] vc;
    logic                de;
    logic                hs;
    logic                vs;
  } vga_fc_t;
endpackage

module video_pixel_src
  import video_pkg::*;
#(
  parameter int RGB_SIZE = 12,
  parameter int HSIZE    = 640,
  parameter int VSIZE    = 480,
  parameter int CNT_W    = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                avs_write,
  input  logic [3:0]          avs_address,
  input  logic [31:0]         avs_writedata,
  input  logic                snk_rdy,
  output logic                snk_vld,
  output vga_fc_t             snk_fc,
  output logic [RGB_SIZE-1:0] snk_rgb,
  output logic                snk_sof,
  output logic                snk_eof
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HSIZE - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VSIZE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, next_state;

  logic                enable;
  logic                mode;
  logic [RGB_SIZE-1:0] bg_color;
  logic                act_mode;
  logic [RGB_SIZE-1:0] act_color;
  logic [CNT_W-1:0]    hc, vc;

  logic                xfer;
  logic                load_first;
  logic                frame_mode;
  logic [RGB_SIZE-1:0] frame_color;
  logic                nxt_vld;
  logic [CNT_W-1:0]    nxt_hc, nxt_vc;
  logic                nxt_sof, nxt_eof;
  logic [RGB_SIZE-1:0] nxt_rgb;

  // Only the low colour bits and ctrl bits 1:0 are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:RGB_SIZE];

  assign xfer = snk_vld & snk_rdy;

  // Register port; addresses other than 0x0 and 0x4 are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable   <= 1'b0;
      mode     <= 1'b0;
      bg_color <= '0;
    end else if (avs_write) begin
      case (avs_address)
        4'h0: begin
          enable <= avs_writedata[0];
          mode   <= avs_writedata[1];
        end
        4'h4: bg_color <= avs_writedata[RGB_SIZE-1:0];
        default: ;
      endcase
    end
  end

  // Shadows sample the registers before any same-cycle write lands, so a
  // write coinciding with the frame reload only takes effect one frame later.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_mode  <= 1'b0;
      act_color <= '0;
    end else if (load_first) begin
      act_mode  <= mode;
      act_color <= bg_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (enable) next_state = RUN;
      RUN:  if (xfer && snk_eof && !enable) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Computes the beat to present next cycle. The colour is derived from the
  // next counters so rgb and hc/vc are registered together.
  always_comb begin
    load_first  = 1'b0;
    nxt_vld     = snk_vld;
    nxt_hc      = hc;
    nxt_vc      = vc;
    frame_mode  = act_mode;
    frame_color = act_color;
    case (state)
      IDLE: begin
        if (enable) begin
          load_first = 1'b1;
          nxt_vld    = 1'b1;
          nxt_hc     = '0;
          nxt_vc     = '0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (snk_eof) begin
            nxt_hc = '0;
            nxt_vc = '0;
            if (enable) load_first = 1'b1;
            else        nxt_vld    = 1'b0;
          end else if (hc == H_LAST) begin
            nxt_hc = '0;
            nxt_vc = vc + 1'b1;
          end else begin
            nxt_hc = hc + 1'b1;
          end
        end
      end
      default: ;
    endcase
    // The first beat of a frame already uses the values being shadowed.
    if (load_first) begin
      frame_mode  = mode;
      frame_color = bg_color;
    end
    nxt_sof = nxt_vld && (nxt_hc == '0) && (nxt_vc == '0);
    nxt_eof = nxt_vld && (nxt_hc == H_LAST) && (nxt_vc == V_LAST);
    nxt_rgb = (frame_mode && (nxt_hc[5] ^ nxt_vc[5])) ? ~frame_color : frame_color;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snk_vld <= 1'b0;
      hc      <= '0;
      vc      <= '0;
      snk_rgb <= '0;
      snk_sof <= 1'b0;
      snk_eof <= 1'b0;
    end else begin
      snk_vld <= nxt_vld;
      hc      <= nxt_hc;
      vc      <= nxt_vc;
      snk_rgb <= nxt_rgb;
      snk_sof <= nxt_sof;
      snk_eof <= nxt_eof;
    end
  end

  always_comb begin
    snk_fc    = '0;
    snk_fc.hc = FC_CNT_W'(hc);
    snk_fc.vc = FC_CNT_W'(vc);
  end

endmodule

// File: tb/tb_video_pixel_src.sv
// tb_video_pixel_src
//   Randomized bench for video_pixel_src on a reduced 72x40 frame. A pixel-index
//   model tracks which beat should be on the output and which colour settings
//   the current frame uses. Every cycle the DUT outputs are compared against it.

module tb_video_pixel_src;
  import video_pkg::*;

  localparam int H    = 72;
  localparam int V    = 40;
  localparam int LAST = H * V - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        avs_write;
  logic [3:0]  avs_address;
  logic [31:0] avs_writedata;
  logic        snk_rdy;
  logic        snk_vld;
  vga_fc_t     snk_fc;
  logic [11:0] snk_rgb;
  logic        snk_sof;
  logic        snk_eof;

  int total = 0;
  int bad   = 0;

  // Model: programmed registers, frame settings, and position as a pixel index.
  bit          m_en, m_mode;
  logic [11:0] m_col;
  bit          run;
  int          pix;
  bit          f_mode;
  logic [11:0] f_col;
  bit          rgb_zero;
  int          f_beats;
  int          rdy_pct;

  video_pixel_src #(.RGB_SIZE(12), .HSIZE(H), .VSIZE(V), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .avs_write(avs_write), .avs_address(avs_address),
    .avs_writedata(avs_writedata), .snk_rdy(snk_rdy), .snk_vld(snk_vld),
    .snk_fc(snk_fc), .snk_rgb(snk_rgb), .snk_sof(snk_sof), .snk_eof(snk_eof)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pix_color(int x, int y, bit m, logic [11:0] c);
    if (m && (((x / 32) + (y / 32)) % 2 == 1)) return ~c;
    return c;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h (pix=%0d)", name, act, exp, pix);
    end
  endtask

  task automatic checkOutput();
    int x, y;
    x = pix % H;
    y = pix / H;
    check("vld", 32'(snk_vld), 32'(run));
    check("hc", 32'(snk_fc.hc), run ? x : 0);
    check("vc", 32'(snk_fc.vc), run ? y : 0);
    check("fc_other", {29'd0, snk_fc.de, snk_fc.hs, snk_fc.vs}, 32'd0);
    check("sof", 32'(snk_sof), 32'(run && pix == 0));
    check("eof", 32'(snk_eof), 32'(run && pix == LAST));
    if (run) check("rgb", 32'(snk_rgb), 32'(pix_color(x, y, f_mode, f_col)));
    else if (rgb_zero) check("rgb_reset", 32'(snk_rgb), 32'd0);
    // Hand-computed checkerboard points for the green checker frame.
    if (run && f_mode && f_col == 12'h0F0) begin
      if (pix == 0)          check("lit_0_0", 32'(snk_rgb), 32'h0F0);
      if (pix == 32)         check("lit_32_0", 32'(snk_rgb), 32'hF0F);
      if (pix == 32 * H + 32) check("lit_32_32", 32'(snk_rgb), 32'h0F0);
      if (pix == 32 * H)     check("lit_0_32", 32'(snk_rgb), 32'hF0F);
    end
  endtask

  task automatic applyStimulus(bit r, bit w, logic [3:0] a, logic [31:0] d, bit rdy);
    rst           = r;
    avs_write     = w;
    avs_address   = a;
    avs_writedata = d;
    snk_rdy       = rdy;
    if (r) begin
      m_en = 0; m_mode = 0; m_col = '0;
      run = 0; pix = 0; f_mode = 0; f_col = '0;
      rgb_zero = 1; f_beats = 0;
    end else begin
      if (!run) begin
        if (m_en) begin
          run = 1; pix = 0; f_mode = m_mode; f_col = m_col;
          rgb_zero = 0; f_beats = 0;
        end
      end else if (rdy) begin
        f_beats++;
        if (pix == LAST) begin
          check("frame_beats", f_beats, 32'd2880);
          f_beats = 0;
          pix = 0;
          if (m_en) begin
            f_mode = m_mode; f_col = m_col;
          end else begin
            run = 0;
          end
        end else begin
          pix++;
        end
      end
      if (w) begin
        if (a == 4'h0) begin
          m_en = d[0]; m_mode = d[1];
        end else if (a == 4'h4) begin
          m_col = d[11:0];
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    avs_write = 1'b0;
    checkOutput();
  endtask

  function automatic bit rand_rdy();
    if (rdy_pct >= 100) return 1'b1;
    return $urandom_range(99) < rdy_pct;
  endfunction

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'h0, 32'h0, rand_rdy());
  endtask

  task automatic write_reg(logic [3:0] a, logic [31:0] d);
    applyStimulus(0, 1, a, d, rand_rdy());
  endtask

  task automatic run_until(bit want_run, int target, int budget);
    int n = 0;
    while (!(run == want_run && (!want_run || pix == target))) begin
      if (n >= budget) begin
        check("timeout", 32'(n), 32'(budget + 1));
        break;
      end
      applyStimulus(0, 0, 4'h0, 32'h0, rand_rdy());
      n++;
    end
  endtask

  initial begin
    avs_write = 0; avs_address = '0; avs_writedata = '0; snk_rdy = 0; rst = 1;
    rdy_pct = 100;
    @(negedge clk);
    // Reset state and staying idle while disabled
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 4'h0, 32'h0, 1'b0);
    idle(5);

    // Solid red, full rate, one whole frame plus the wrap into the next
    write_reg(4'h4, 32'h0000_0F00);
    write_reg(4'h0, 32'h1);
    run_until(1, LAST, 4000);
    idle(3);

    // Checker green requested mid-frame applies from the next frame
    write_reg(4'h4, 32'h0000_00F0);
    write_reg(4'h0, 32'h3);
    run_until(1, LAST, 4000);
    rdy_pct = 50;
    run_until(1, 32 * H + 40, 12000);

    // Colour change mid-frame: remainder stays green, next frame blue
    write_reg(4'h4, 32'h0000_000F);
    run_until(1, LAST, 12000);
    idle(1);

    // Write landing on the same edge as the frame reload
    run_until(1, LAST, 12000);
    applyStimulus(0, 1, 4'h4, 32'h0000_0ABC, 1'b1);
    run_until(1, 200, 12000);

    // Disable mid-frame: frame completes, then output stops
    write_reg(4'h0, 32'h0);
    run_until(0, 0, 12000);
    idle(10);
    write_reg(4'h8, 32'h3);
    write_reg(4'hC, 32'h1);
    idle(5);
    write_reg(4'h0, 32'h1);
    run_until(1, 500, 4000);

    // Reset during a frame at (30,10)
    run_until(1, 10 * H + 30, 12000);
    applyStimulus(1, 0, 4'h0, 32'h0, rand_rdy());
    idle(8);
    write_reg(4'h0, 32'h3);

    // Random register traffic, including ignored addresses
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(99) < 2) begin
        logic [3:0] a;
        logic [31:0] d;
        a = 4'($urandom_range(3) * 4);
        d = $urandom;
        if (a == 4'h0 && $urandom_range(3) != 0) d[0] = 1'b1;
        write_reg(a, d);
      end else begin
        idle(1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
